dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory (DMEM) between the CPU data port and a debug read port. The debug port can read any DMEM word for the seven-segment display or a host probe. The block sits between `CPU` and `DMEM` inside the `sccomp_dataflow` top level. The CPU always has priority. Debug reads take idle CPU memory cycles, or steal one CPU cycle by deasserting CPU `ena` once a starvation limit is reached. The block also converts byte addresses to word addresses and flags illegal addresses.

## Interface
Parameters:
- `ADDR_W`, 11: DMEM word-address width (2^ADDR_W words).
- `BASE`, 32'h1001_0000: byte address of DMEM word 0.
- `STARVE_LIMIT`, 8: number of waiting cycles a debug request tolerates before stealing a CPU cycle (≥1).

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `cpu_dm_ena`, in, 1: CPU memory enable.
- `cpu_dm_w`, in, 1: CPU write strobe.
- `cpu_dm_r`, in, 1: CPU read strobe.
- `cpu_addr`, in, 32: CPU byte address.
- `cpu_wdata`, in, 32: CPU write data.
- `cpu_rdata`, out, 32: read data returned to the CPU.
- `cpu_ena`, out, 1: CPU enable. 0 freezes the PC and the register file for that cycle.
- `cpu_addr_err`, out, 1: CPU access to an illegal address this cycle (combinational).
- `dbg_req`, in, 1: debug read request (level).
- `dbg_addr`, in, 32: debug byte address.
- `dbg_ack`, out, 1: one-cycle completion pulse.
- `dbg_rdata`, out, 32: registered debug read data.
- `dbg_err`, out, 1: registered illegal-address flag, valid with `dbg_ack`.
- `dm_w`, out, 1: DMEM write strobe.
- `dm_r`, out, 1: DMEM read strobe.
- `dm_addr`, out, ADDR_W: DMEM word address.
- `dm_wdata`, out, 32: DMEM write data.
- `dm_rdata`, in, 32: DMEM read data (combinational read).

## Operation
Address translation:
- `word = (addr - BASE) >> 2`.
- An address is illegal if any of these hold: `addr < BASE`, `addr[1:0] != 0`, or `word >= 2^ADDR_W`.

CPU access:
- A CPU access is `cpu_dm_ena & (cpu_dm_r | cpu_dm_w)`.
- Illegal CPU address: `dm_w` forced to 0, `cpu_addr_err=1`, `cpu_rdata=0`.

DMEM mux:
- Default: CPU address and data drive DMEM; `cpu_rdata = dm_rdata`.
- During a debug grant: DMEM gets the captured debug address, `dm_r=1`, `dm_w=0`.

FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If `dbg_req`: capture `dbg_addr` into `dbg_addr_q`, clear `wait_cnt`, go to WAIT.
- WAIT:
  - Debug address illegal: go to ACK with `dbg_err=1`, `dbg_rdata=0`. No DMEM access and no steal.
  - Natural grant (no CPU access this cycle): latch `dbg_rdata<=dm_rdata`, `dbg_err<=0`, go to ACK.
  - Forced grant (`wait_cnt==STARVE_LIMIT`): `cpu_ena=0` for this cycle only. The CPU access is suppressed and the CPU retries on the next cycle. Then latch data as for a natural grant and go to ACK.
  - Otherwise: `wait_cnt++` and stay in WAIT.
- ACK:
  - `dbg_ack=1` for exactly one cycle, then go to IDLE.
  - A request still high in IDLE is treated as a new request.

Counter and outputs:
- `wait_cnt` is `$clog2(STARVE_LIMIT+1)` bits wide and saturates at `STARVE_LIMIT`.
- `cpu_ena=1` in every cycle except a forced grant.

## Timing
Latency:
- Request sampled at edge t0, WAIT entered at t1.
- Best case: grant in cycle t1, `dbg_ack` high in cycle t2.
- Worst case: `dbg_ack` in cycle t0+STARVE_LIMIT+2.
- At most one stolen CPU cycle per debug request.

Reset (`rst=0`, applied on the edge):
- State goes to IDLE; `wait_cnt=0`, `dbg_ack=0`, `dbg_rdata=0`, `dbg_err=0`.
- While `rst=0`: `dm_w=0` and `cpu_ena=1` (combinational gating).
- Reset during WAIT or ACK drops the request; no ack is issued.

Simultaneous events:
- CPU write in a forced-grant cycle: the write is not performed and is re-issued next cycle.
- CPU read in the same cycle as a natural grant is impossible by definition.

`dbg_addr` changes after capture are ignored.

## Structure
Package `dmem_arb_pkg`:
- FSM state enum `arb_state_t` (IDLE, WAIT, ACK).
- Default `BASE` constant.
- Address-legality function.

Sub-module `dm_addr_xlate`:
- Combinational: byte address in, word address and illegal flag out.
- Instantiated twice, once for the CPU port and once for the debug port.

## Test plan
- Debug read, CPU idle: preload word 5 = 32'hDEAD_BEEF, `dbg_req` with 32'h1001_0014 → ack two cycles after the request edge, `dbg_rdata`=32'hDEAD_BEEF, `cpu_ena` never 0.
- Starvation steal: CPU accesses every cycle, `STARVE_LIMIT`=8 → exactly one cycle with `cpu_ena=0` at WAIT cycle 9; ack in the next cycle; the CPU write to 32'h1001_0000 in the stolen cycle lands one cycle later.
- Illegal addresses:
  - Debug address 32'h1001_0002 → `dbg_ack` with `dbg_err=1`, `dbg_rdata=0`, no steal.
  - CPU write to 32'h1000_FFFC → `dm_w=0`, `cpu_addr_err=1`.
- Upper boundary: 32'h1001_1FFC is legal (word 2047); 32'h1001_2000 is illegal.
- Reset mid-WAIT: pull `rst` low for 1 cycle → no ack, state IDLE, `dm_w=0` during reset.
- Back-to-back requests: hold `dbg_req` high → acks every 3 cycles with the CPU idle; each ack carries the address captured at its own IDLE edge.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the DMEM arbiter: FSM states, the default
// DMEM base address and the byte-address legality rule.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   localparam logic [31:0] DEFAULT_BASE = 32'h1001_0000;

   // An address is illegal when it lies below the base, is not word aligned,
   // or maps past the last word. word >= 2^addr_w is the same as the byte
   // offset having any bit set at or above position addr_w+2.
   function automatic logic addr_illegal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned addr_w);
      logic [31:0] offset;
      offset = addr - base;
      return (addr < base) || (addr[1:0] != 2'b00) ||
             ((offset >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dm_addr_xlate.sv
// Combinational byte-to-word address translation with an illegal-address flag.
module dm_addr_xlate
   import dmem_arb_pkg::*;
#(
   parameter int          ADDR_W = 11,
   parameter logic [31:0] BASE   = DEFAULT_BASE
) (
   input  logic [31:0]       byte_addr,
   output logic [ADDR_W-1:0] word_addr,
   output logic              illegal
);

   // Word address is only meaningful when illegal is low.
   assign word_addr = ADDR_W'((byte_addr - BASE) >> 2);
   assign illegal   = addr_illegal(byte_addr, BASE, ADDR_W);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the CPU data port (always preferred)
// and a debug read port. A waiting debug read takes an idle CPU memory cycle,
// or steals exactly one CPU cycle once it has waited STARVE_LIMIT cycles.
//
// state | meaning
// IDLE  | no debug read pending; a high dbg_req is captured here
// WAIT  | debug address captured, waiting for an idle CPU cycle or starvation
// ACK   | dbg_ack high for this single cycle with dbg_rdata / dbg_err valid
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int          ADDR_W       = 11,
   parameter logic [31:0] BASE         = DEFAULT_BASE,
   parameter int          STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_dm_ena,
   input  logic              cpu_dm_w,
   input  logic              cpu_dm_r,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ena,
   output logic              cpu_addr_err,
   input  logic              dbg_req,
   input  logic [31:0]       dbg_addr,
   output logic              dbg_ack,
   output logic [31:0]       dbg_rdata,
   output logic              dbg_err,
   output logic              dm_w,
   output logic              dm_r,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   input  logic [31:0]       dm_rdata
);

   localparam int            CW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

   arb_state_t        state;
   logic [CW-1:0]     wait_cnt;
   logic [31:0]       dbg_addr_q;

   logic [ADDR_W-1:0] cpu_word;
   logic [ADDR_W-1:0] dbg_word;
   logic              cpu_illegal;
   logic              dbg_illegal;
   logic              cpu_acc;
   logic              nat_grant;
   logic              force_grant;
   logic              grant;

   dm_addr_xlate #(.ADDR_W(ADDR_W), .BASE(BASE)) u_cpu_xlate (
      .byte_addr (cpu_addr),
      .word_addr (cpu_word),
      .illegal   (cpu_illegal)
   );

   dm_addr_xlate #(.ADDR_W(ADDR_W), .BASE(BASE)) u_dbg_xlate (
      .byte_addr (dbg_addr_q),
      .word_addr (dbg_word),
      .illegal   (dbg_illegal)
   );

   // Grant decision: an illegal debug address never touches DMEM or the CPU.
   // Everything is gated by rst so a reset cycle performs no debug access.
   assign cpu_acc     = cpu_dm_ena & (cpu_dm_r | cpu_dm_w);
   assign nat_grant   = rst & (state == WAIT) & ~dbg_illegal & ~cpu_acc;
   assign force_grant = rst & (state == WAIT) & ~dbg_illegal & cpu_acc &
                        (wait_cnt == CNT_MAX);
   assign grant       = nat_grant | force_grant;

   // CPU side: a stolen cycle freezes the CPU so it re-issues its access.
   assign cpu_ena      = ~force_grant;
   assign cpu_addr_err = cpu_acc & cpu_illegal;
   assign cpu_rdata    = cpu_illegal ? 32'h0 : dm_rdata;

   // DMEM mux: the captured debug address owns the port during a grant.
   assign dm_addr  = grant ? dbg_word : cpu_word;
   assign dm_w     = rst & ~grant & cpu_dm_ena & cpu_dm_w & ~cpu_illegal;
   assign dm_r     = grant | (rst & cpu_dm_ena & cpu_dm_r & ~cpu_illegal);
   assign dm_wdata = cpu_wdata;

   // Debug request FSM with registered ack, data and error outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         dbg_addr_q <= '0;
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
         dbg_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dbg_ack <= 1'b0;
               if (dbg_req) begin
                  dbg_addr_q <= dbg_addr;
                  wait_cnt   <= '0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (dbg_illegal) begin
                  dbg_rdata <= '0;
                  dbg_err   <= 1'b1;
                  dbg_ack   <= 1'b1;
                  state     <= ACK;
               end else if (grant) begin
                  dbg_rdata <= dm_rdata;
                  dbg_err   <= 1'b0;
                  dbg_ack   <= 1'b1;
                  state     <= ACK;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACK: begin
               dbg_ack <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               dbg_ack <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
